// File: rtl/bcd_key_pkg.sv
// Shared types and helpers for the pushbutton-driven BCD counter.
// Debounce FSM states, BCD limits and the single-digit step function.
package bcd_key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Returns {wrap, next_digit} for one step up or down modulo 10.
  function automatic logic [4:0] bcd_step(input logic [3:0] value, input logic up);
    logic [4:0] result;
    if (up) begin
      result = (value == BCD_MAX) ? {1'b1, BCD_MIN} : {1'b0, value + 4'd1};
    end else begin
      result = (value == BCD_MIN) ? {1'b1, BCD_MAX} : {1'b0, value - 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchronizer plus press/release debounce FSM emitting a one-cycle evt.
// BCD_KEY_COUNTER_AUTO_REPEAT_EN adds a repeat timer that fires extra events while held.
module key_debounce
  import bcd_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
`ifdef BCD_KEY_COUNTER_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 10000000,
  parameter int REPEAT_PERIOD = 2500000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Sync flops reset to "released" so leaving reset never looks like a press.
  logic key_meta_q;
  logic key_s_q;

  key_state_e      state_q, state_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            press_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      state_q    <= IDLE;
      dcnt_q     <= '0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    press_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s_q) begin
          state_d = IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d   = HELD;
          dcnt_d    = '0;
          press_evt = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      HELD: begin
        if (key_s_q) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s_q) begin
          state_d = HELD;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BCD_KEY_COUNTER_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RDELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rfirst_q, rfirst_d;
  logic          rep_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q   <= '0;
      rfirst_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rfirst_q <= rfirst_d;
    end
  end

  // Only cycles that stay in HELD advance the timer; any exit wipes it.
  always_comb begin
    rcnt_d   = '0;
    rfirst_d = 1'b0;
    rep_evt  = 1'b0;
    if (state_q == HELD && !key_s_q) begin
      rfirst_d = rfirst_q;
      if (rcnt_q == (rfirst_q ? RPERIOD_LAST : RDELAY_LAST)) begin
        rep_evt  = 1'b1;
        rfirst_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
  end

  assign evt = press_evt | rep_evt;
`else
  assign evt = press_evt;
`endif

endmodule

// File: rtl/bcd_key_counter.sv
// Debounced pushbutton driving a 0..9 up/down counter for the seven-segment decoder.
// Optional auto-repeat while held: define BCD_KEY_COUNTER_AUTO_REPEAT_EN.
module bcd_key_counter
  import bcd_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 10000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       dir,
  input  logic       clr,
  output logic [3:0] data,
  output logic       carry,
  output logic       pressed
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("bcd_key_counter: parameter out of legal range");
  end

  logic evt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BCD_KEY_COUNTER_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_key_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .evt  (evt)
  );

  logic       dir_meta_q;
  logic       dir_s_q;
  logic [3:0] data_q, data_d;
  logic       carry_q, carry_d;
  logic       pressed_q, pressed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_meta_q <= 1'b1;
      dir_s_q    <= 1'b1;
      data_q     <= BCD_MIN;
      carry_q    <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      dir_meta_q <= dir;
      dir_s_q    <= dir_meta_q;
      data_q     <= data_d;
      carry_q    <= carry_d;
      pressed_q  <= pressed_d;
    end
  end

  // clr wins over a coincident event, but the press is still reported.
  always_comb begin
    data_d    = data_q;
    carry_d   = 1'b0;
    pressed_d = evt;
    if (clr) begin
      data_d = BCD_MIN;
    end else if (evt) begin
      {carry_d, data_d} = bcd_step(data_q, dir_s_q);
    end
  end

  assign data    = data_q;
  assign carry   = carry_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_bcd_key_counter.sv
// Scoreboard bench for bcd_key_counter: a run-length debounce model predicts every cycle.
// Repeat expectations follow BCD_KEY_COUNTER_AUTO_REPEAT_EN.
module tb_bcd_key_counter;

  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       dir = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] data;
  logic       carry;
  logic       pressed;

  bcd_key_counter #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .dir    (dir),
    .clr    (clr),
    .data   (data),
    .carry  (carry),
    .pressed(pressed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    logic       carry;
    logic       pressed;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_press = 0;
  int   n_carry = 0;

  // Reference model: key/dir seen through a 2-edge delay, press accepted after
  // the delayed key has been low on DC+1 consecutive edges, release likewise.
  logic m_s1, m_ks, m_d1, m_ds, m_prev;
  bit   m_up, m_in_held;
  int   m_run, m_hold, m_data;

  task automatic model_reset();
    m_s1 = 1'b1; m_ks = 1'b1; m_d1 = 1'b1; m_ds = 1'b1;
    m_prev = 1'b1; m_run = DC + 2;
    m_up = 1'b1; m_in_held = 1'b0; m_hold = 0; m_data = 0;
  endtask

  task automatic model_step();
    bit   ev;
    bit   c;
    logic v;
    exp_t e;
    ev = 1'b0;
    c  = 1'b0;
    v  = m_ks;
    m_run  = (v == m_prev) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_prev = v;
    if (m_up) begin
      if (!v && m_run == DC + 1) begin
        ev = 1'b1; m_up = 1'b0; m_in_held = 1'b1; m_hold = 0;
      end
    end else if (v) begin
      m_in_held = 1'b0;
      if (m_run == DC + 1) m_up = 1'b1;
    end else if (!m_in_held) begin
      m_in_held = 1'b1; m_hold = 0;
    end else begin
      m_hold++;
`ifdef BCD_KEY_COUNTER_AUTO_REPEAT_EN
      if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) ev = 1'b1;
`endif
    end
    if (clr) begin
      m_data = 0;
    end else if (ev) begin
      if (m_ds) begin
        c = (m_data == 9); m_data = (m_data + 1) % 10;
      end else begin
        c = (m_data == 0); m_data = (m_data + 9) % 10;
      end
    end
    e.data = 4'(m_data); e.carry = c; e.pressed = ev;
    exp_q.push_back(e);
    m_ks = m_s1; m_s1 = key_n;
    m_ds = m_d1; m_d1 = dir;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor: every cycle the DUT presents a registered output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (data !== e.data || carry !== e.carry || pressed !== e.pressed) begin
          n_bad++;
          if (n_bad < 30)
            $display("FAIL scoreboard t=%0t: got data=%0d carry=%b pressed=%b, want data=%0d carry=%b pressed=%b",
                     $time, data, carry, pressed, e.data, e.carry, e.pressed);
        end else if (e.pressed) begin
          $display("event t=%0t data=%0d carry=%b", $time, data, carry);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (pressed === 1'b1) n_press++;
        if (carry === 1'b1) n_carry++;
      end
    end
  end

  task automatic check(string name, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int lo, int hi);
    key_n = 1'b0;
    cyc(lo);
    key_n = 1'b1;
    cyc(hi);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c0;
    cyc(3);
    #2 rst_n = 1'b1;
    cyc(4);
    check("post_reset_data", int'(data), 0);

    // Clean press: one event, then nothing through release and idle.
    p0 = n_press;
    press(12, 14);
    check("clean_press_count", n_press - p0, 1);
    check("clean_press_data", int'(data), 1);

    // Count up to 5, then reset while the next press is debouncing.
    repeat (4) press(8, 8);
    check("pre_reset_data", int'(data), 5);
    key_n = 1'b0;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_data", int'(data), 0);
    check("async_reset_carry", int'(carry), 0);
    check("async_reset_pressed", int'(pressed), 0);
    key_n = 1'b1;
    cyc(3);
    #2 rst_n = 1'b1;
    cyc(10);
    check("reset_release_data", int'(data), 0);

    // Bounce train then one stable press.
    p0 = n_press;
    repeat (5) begin
      key_n = 1'b0; cyc(2);
      key_n = 1'b1; cyc(1);
    end
    check("bounce_no_count", n_press - p0, 0);
    press(12, 10);
    check("bounce_one_count", n_press - p0, 1);
    check("bounce_data", int'(data), 1);

    // Wrap up and borrow down.
    pulse_clr();
    dir = 1'b1;
    c0 = n_carry;
    repeat (9) press(8, 8);
    check("up_to_9_data", int'(data), 9);
    check("up_to_9_no_carry", n_carry - c0, 0);
    press(8, 8);
    check("wrap_data", int'(data), 0);
    check("wrap_carry", n_carry - c0, 1);
    dir = 1'b0;
    press(8, 8);
    check("borrow_data", int'(data), 9);
    check("borrow_carry", n_carry - c0, 2);

    // clr coincident with the event edge at data=7.
    repeat (2) press(8, 8);
    check("pre_clr_data", int'(data), 7);
    dir = 1'b1;
    cyc(3);
    p0 = n_press;
    c0 = n_carry;
    key_n = 1'b0;
    cyc(6);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(5);
    key_n = 1'b1;
    cyc(10);
    check("clr_pressed", n_press - p0, 1);
    check("clr_data", int'(data), 0);
    check("clr_no_carry", n_carry - c0, 0);
    press(8, 8);
    check("after_clr_data", int'(data), 1);

    // Long hold: HELD lasts 18 cycles.
    pulse_clr();
    press(22, 10);
`ifdef BCD_KEY_COUNTER_AUTO_REPEAT_EN
    check("hold_data", int'(data), 4);
`else
    check("hold_data", int'(data), 1);
`endif

    // Random key activity, direction flips and clears.
    for (int i = 0; i < 150; i++) begin
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      clr = ($urandom_range(0, 15) == 0);
      cyc(1);
      clr = 1'b0;
      cyc($urandom_range(0, 9));
    end
    key_n = 1'b1;
    cyc(12);
    check("final_model_data", int'(data), m_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_key_counter.md
Name: bcd_key_counter

Overview:
- Upstream stage of the single-digit seven-segment decoder.
- Synchronizes and debounces a raw pushbutton and counts each accepted press modulo 10, up or down.
- Drives a 4-bit BCD value `data` that connects directly to the decoder's `data` input.
- `data` never leaves 0..9, so the decoder's "E" pattern is never displayed.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release. Legal range ≥ 2.
- REPEAT_DELAY, 10000000: cycles in HELD before the first auto-repeat event. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 2500000: cycles between subsequent auto-repeat events. Used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock; all flops rise-edge.
- rst_n  input  1  asynchronous active-low reset.
- key_n  input  1  raw pushbutton, active low, asynchronous, bouncy.
- dir  input  1  count direction from a slide switch, asynchronous; 1 = up, 0 = down.
- clr  input  1  synchronous clear, active high, already in the clk domain.
- data  output  4  registered BCD count; feeds the decoder.
- carry  output  1  one-cycle pulse on wrap: 9→0 counting up, or 0→9 counting down (borrow).
- pressed  output  1  one-cycle pulse on every accepted count event.

Behaviour:
- Reset: rst_n low asynchronously forces data=0, carry=0, pressed=0, FSM=IDLE, all counters=0. Applies at any time, including mid-debounce.
- Synchronizers: key_n and dir each pass through 2 flops, giving key_s and dir_s. key_s reflects key_n after the 2nd edge.
- Debounce FSM, driven by key_s with counter dcnt:
  - IDLE: on key_s=0 go to PRESS_WAIT with dcnt=0.
  - PRESS_WAIT: on key_s=1 return to IDLE (bounce rejected; the restart is full). Otherwise dcnt++. When dcnt==DEBOUNCE_CYCLES-1 and key_s=0, go to HELD and raise a count event.
  - HELD: on key_s=1 go to RELEASE_WAIT with dcnt=0.
  - RELEASE_WAIT: on key_s=0 return to HELD with no event. Otherwise dcnt++. When dcnt==DEBOUNCE_CYCLES-1 and key_s=1, go to IDLE.
- Latency: key_n stably low before edge E0 gives PRESS_WAIT at E2. data, pressed and carry all update at edge E(2+DEBOUNCE_CYCLES).
- Count event handling, all on the same edge:
  - pressed=1 for exactly one cycle.
  - If dir_s=1: data = (data==9) ? 0 : data+1.
  - If dir_s=0: data = (data==0) ? 9 : data-1.
  - carry=1 for exactly one cycle only on a wrap.
- clr:
  - clr=1 forces data=0 and carry=0 on the next edge.
  - clr has priority over a coincident count event. The event's data update and carry are dropped, but pressed still pulses.
  - The FSM is unaffected by clr.
- At most one count event per press/release cycle; holding the key does not count again unless AUTO_REPEAT_EN is defined.
- dcnt width is $clog2(DEBOUNCE_CYCLES). There are no other arithmetic widths beyond 4-bit BCD.

Optional Feature:
- Macro: BCD_KEY_COUNTER_AUTO_REPEAT_EN.
- Defined: a repeat timer runs while the FSM is in HELD.
  - The first extra count event fires REPEAT_DELAY cycles after entering HELD, then one every REPEAT_PERIOD cycles.
  - Each repeat event is handled exactly like a normal count event (pressed, carry, clr priority).
  - The timer resets to 0 on leaving HELD and does not resume from RELEASE_WAIT→HELD bounces.
- Undefined: no repeat timer logic; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Decomposition:
- Package bcd_key_pkg:
  - FSM state enum: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - Constants BCD_MAX=4'd9 and BCD_MIN=4'd0.
- Sub-module key_debounce:
  - Contains the key_n synchronizer, the FSM and dcnt (plus the repeat timer under the macro).
  - Outputs a single-cycle evt.
- The top level holds the dir synchronizer, the BCD counter and the clr, carry and pressed logic.

Test Plan (DEBOUNCE_CYCLES=4; REPEAT_DELAY=8 and REPEAT_PERIOD=4 where used):
- Reset mid-PRESS_WAIT with data=5: drop rst_n between edges → data=0, carry=0, pressed=0 immediately without a clock edge. Releasing reset with the key up keeps data=0.
- Clean press, dir=1, key_n low from before E0 for 12 cycles then high → single pressed pulse at E6, data 0→1. No further change through release and 10 idle cycles.
- Bounce: key_n low for 2 cycles and high for 1, repeated 5 times, then stable low → no count during bounces. Exactly one count, at 6 edges after the final stable fall.
- Wrap: 10 clean presses up from 0 → data reaches 9 with no carry, then 9→0 with a carry pulse on the 10th. With dir=0 from 0, one press → data=9 with a carry pulse.
- Coincident clr: assert clr on the edge a count event fires with data=7 → data=0, carry=0, pressed=1. The next press gives data=1.
- With BCD_KEY_COUNTER_AUTO_REPEAT_EN, hold the key so HELD lasts 18 cycles → events at HELD entry, +8, +12 and +16, so data 0→4. Without the macro, the same stimulus gives data 0→1.
